// File: rtl/e203_exu_wbck_merge.sv
// e203_exu_wbck_merge
//  Merges the ALU and long-pipe write-back streams into the single integer
//  regfile write port. The long pipe wins by default; an ALU that keeps
//  losing is forced through after STARVE_MAX consecutive losses. Accepted
//  writes go through a DEPTH-entry in-order buffer towards the regfile.
//  A combinational lookup reports whether a register has a buffered write.

`ifndef E203_XLEN
`define E203_XLEN 32
`endif
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif

module e203_exu_wbck_merge #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         alu_wbck_i_valid,
    output logic                         alu_wbck_i_ready,
    input  logic [`E203_XLEN-1:0]        alu_wbck_i_wdat,
    input  logic [`E203_RFIDX_WIDTH-1:0] alu_wbck_i_rdidx,

    input  logic                         longp_wbck_i_valid,
    output logic                         longp_wbck_i_ready,
    input  logic [`E203_XLEN-1:0]        longp_wbck_i_wdat,
    input  logic [`E203_RFIDX_WIDTH-1:0] longp_wbck_i_rdidx,

    output logic                         rf_wbck_o_valid,
    input  logic                         rf_wbck_o_ready,
    output logic [`E203_XLEN-1:0]        rf_wbck_o_wdat,
    output logic [`E203_RFIDX_WIDTH-1:0] rf_wbck_o_rdidx,

    input  logic [`E203_RFIDX_WIDTH-1:0] dep_chk_rdidx,
    output logic                         dep_chk_hit
);

    localparam int unsigned XLEN  = `E203_XLEN;
    localparam int unsigned RFW   = `E203_RFIDX_WIDTH;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Buffer storage and bookkeeping
    logic [XLEN-1:0]  wdat_mem_q  [DEPTH];
    logic [RFW-1:0]   rdidx_mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [3:0]       starve_cnt_q, starve_cnt_d;

    // Arbitration and handshake terms
    logic             full;
    logic             empty;
    logic             force_alu;
    logic             alu_acc;
    logic             longp_acc;
    logic             push;
    logic             pop;
    logic [XLEN-1:0]  push_wdat;
    logic [RFW-1:0]   push_rdidx;

    // Dependency lookup scratch
    logic [PTR_W-1:0] ent_off;
    logic             dep_any;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign force_alu = (starve_cnt_q == 4'(STARVE_MAX));

    // Fixed long-pipe priority unless the ALU has been starved long enough
    always_comb begin
        longp_wbck_i_ready = ~full & ~(force_alu & alu_wbck_i_valid);
        alu_wbck_i_ready   = ~full & (~longp_wbck_i_valid | force_alu);
    end

    // Select the accepted source; x0 writes complete the handshake but are dropped
    always_comb begin
        alu_acc   = alu_wbck_i_valid & alu_wbck_i_ready;
        longp_acc = longp_wbck_i_valid & longp_wbck_i_ready;
        if (longp_acc) begin
            push_wdat  = longp_wbck_i_wdat;
            push_rdidx = longp_wbck_i_rdidx;
        end else begin
            push_wdat  = alu_wbck_i_wdat;
            push_rdidx = alu_wbck_i_rdidx;
        end
        push = (alu_acc | longp_acc) & (push_rdidx != '0);
        pop  = ~empty & rf_wbck_o_ready;
    end

    // Pointer, occupancy and starvation next-state
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        starve_cnt_d = starve_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A loss only counts when the buffer had room; a full buffer freezes the count
        if (alu_wbck_i_valid & ~full & ~alu_wbck_i_ready) begin
            if (starve_cnt_q != 4'(STARVE_MAX)) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end else if (alu_acc | ~alu_wbck_i_valid) begin
            starve_cnt_d = '0;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Buffer entry storage, written only on push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                wdat_mem_q[i]  <= '0;
                rdidx_mem_q[i] <= '0;
            end
        end else if (push) begin
            wdat_mem_q[wr_ptr_q]  <= push_wdat;
            rdidx_mem_q[wr_ptr_q] <= push_rdidx;
        end
    end

    // Head entry presented to the regfile; zeros while the buffer is empty
    always_comb begin
        rf_wbck_o_valid = ~empty;
        if (empty) begin
            rf_wbck_o_wdat  = '0;
            rf_wbck_o_rdidx = '0;
        end else begin
            rf_wbck_o_wdat  = wdat_mem_q[rd_ptr_q];
            rf_wbck_o_rdidx = rdidx_mem_q[rd_ptr_q];
        end
    end

    // Pending-write lookup: an entry is live when its distance from the head is below count
    always_comb begin
        ent_off = '0;
        dep_any = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_off = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, ent_off} < count_q) && (rdidx_mem_q[i] == dep_chk_rdidx)) begin
                dep_any = 1'b1;
            end
        end
        dep_chk_hit = dep_any & (dep_chk_rdidx != '0);
    end

endmodule
